// File: rtl/ni_axi4lite_wr_master_if.sv
// Bus bundle for ni_axi4lite_wr_master: NI outbound FIFO read port plus the
// AXI4-Lite write channels (AW, W, B).
// master modport = the write initiator; slave modport = FIFO + interconnect side.
interface ni_axi4lite_wr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // FIFO read port (first-word-fall-through)
  logic              fifo_empty;
  logic [ADDR_W-1:0] fifo_addr;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;

  // AXI4-Lite write address
  logic [ADDR_W-1:0] m_awaddr;
  logic [2:0]        m_awprot;
  logic              m_awvalid;
  logic              m_awready;

  // AXI4-Lite write data
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wvalid;
  logic              m_wready;

  // AXI4-Lite write response
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  modport master (
    input  fifo_empty, fifo_addr, fifo_data,
    output fifo_rd_en,
    output m_awaddr, m_awprot, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output fifo_empty, fifo_addr, fifo_data,
    input  fifo_rd_en,
    input  m_awaddr, m_awprot, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/ni_axi4lite_wr_master.sv
// AXI4-Lite write initiator: pops one FIFO entry per transaction and issues a
// single-beat write (AW + W, then B). One transaction outstanding at a time.
// Ports: clk_i, reset_ni (async active-low), bus (master modport: FIFO read
// port + AW/W/B channels), busy_o, wr_count_o / err_count_o (saturating),
// last_bresp_o.
module ni_axi4lite_wr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  ni_axi4lite_wr_master_if.master bus,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     wr_count_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [1:0]           last_bresp_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_pend_q;
  logic              w_pend_q;
  logic              bready_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [1:0]        last_bresp_q;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;

  assign aw_hs   = aw_pend_q & bus.m_awready;
  assign w_hs    = w_pend_q & bus.m_wready;
  // A channel is finished if it already handshook or is handshaking now.
  assign aw_done = ~aw_pend_q | aw_hs;
  assign w_done  = ~w_pend_q | w_hs;

  // The pop must coincide with the capture edge, so it is decoded from the
  // state register rather than registered itself. Gated by reset so a
  // non-empty FIFO is never popped while the block is held in reset.
  assign bus.fifo_rd_en = reset_ni & (state_q == IDLE) & ~bus.fifo_empty;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      bready_q     <= 1'b0;
      wr_cnt_q     <= '0;
      err_cnt_q    <= '0;
      last_bresp_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.fifo_empty) begin
            awaddr_q  <= bus.fifo_addr;
            wdata_q   <= bus.fifo_data;
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (aw_hs) aw_pend_q <= 1'b0;
          if (w_hs)  w_pend_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (bus.m_bvalid) begin
            last_bresp_q <= bus.m_bresp;
            if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + CNT_ONE;
            if ((bus.m_bresp != 2'b00) && (err_cnt_q != CNT_MAX)) begin
              err_cnt_q <= err_cnt_q + CNT_ONE;
            end
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awprot  = 3'b000;
  assign bus.m_awvalid = aw_pend_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = '1;
  assign bus.m_wvalid  = w_pend_q;
  assign bus.m_bready  = bready_q;

  assign busy_o       = (state_q != IDLE);
  assign wr_count_o   = wr_cnt_q;
  assign err_count_o  = err_cnt_q;
  assign last_bresp_o = last_bresp_q;

endmodule

// File: tb/tb_ni_axi4lite_wr_master.sv
module tb_ni_axi4lite_wr_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ni_axi4lite_wr_master_if #(.ADDR_W(32), .DATA_W(32)) ifc ();
  ni_axi4lite_wr_master_if #(.ADDR_W(32), .DATA_W(32)) ifc2 ();

  logic       busy;
  logic [7:0] wr_count, err_count;
  logic [1:0] last_bresp;
  logic       busy2;
  logic [1:0] wr_count2, err_count2, last_bresp2;

  ni_axi4lite_wr_master #(.ADDR_W(32), .DATA_W(32), .CNT_W(8)) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(ifc.master),
    .busy_o(busy), .wr_count_o(wr_count), .err_count_o(err_count),
    .last_bresp_o(last_bresp)
  );

  // Narrow-counter instance for saturation.
  ni_axi4lite_wr_master #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut2 (
    .clk_i(clk), .reset_ni(rst_n), .bus(ifc2.master),
    .busy_o(busy2), .wr_count_o(wr_count2), .err_count_o(err_count2),
    .last_bresp_o(last_bresp2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } ent_t;

  ent_t fq[$];    // entries sitting in the FIFO model
  ent_t aw_q[$];  // popped, awaiting AW handshake
  ent_t w_q[$];   // popped, awaiting W handshake
  ent_t b_q[$];   // popped, awaiting B handshake

  int n_pass = 0, n_total = 0;
  int cyc = 0, pop_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int last_pop_cyc = 0, prev_pop_cyc = 0;
  int n2 = 0, pop2_cnt = 0;
  bit pop_pending = 0, pop2_pending = 0, rand_rdy = 0;

  // Reference model of the status outputs, derived from the planned entries.
  int         exp_wr = 0, exp_err = 0;
  logic [1:0] exp_last = 2'b00;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void fifo_drive();
    if (fq.size() == 0) begin
      ifc.fifo_empty = 1'b1;
      ifc.fifo_addr  = '0;
      ifc.fifo_data  = '0;
    end else begin
      ifc.fifo_empty = 1'b0;
      ifc.fifo_addr  = fq[0].addr;
      ifc.fifo_data  = fq[0].data;
    end
  endfunction

  task automatic push(logic [31:0] a, logic [31:0] d, logic [1:0] r);
    ent_t e;
    e.addr = a; e.data = d; e.resp = r;
    fq.push_back(e);
    fifo_drive();
    exp_wr   = (exp_wr + 1 > 255) ? 255 : exp_wr + 1;
    if (r != 2'b00) exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
    exp_last = r;
  endtask

  task automatic check_counts(string tag);
    chk({tag, "_wr_count"}, wr_count, exp_wr);
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_last_bresp"}, last_bresp, exp_last);
  endtask

  task automatic wait_done(int budget);
    int k = 0;
    bit ok;
    do begin
      @(negedge clk);
      k++;
      ok = (fq.size() == 0) && !pop_pending && (b_q.size() == 0) && !busy;
    end while (!ok && k < budget);
    chk("done_in_budget", ok, 1'b1);
  endtask

  // Input driver: FIFO pops, B responder, optional random readies.
  always @(posedge clk) begin : drv
    ent_t e;
    #1;
    if (pop_pending) begin
      e = fq.pop_front();
      aw_q.push_back(e);
      w_q.push_back(e);
      b_q.push_back(e);
      pop_pending = 0;
      fifo_drive();
    end
    if (ifc.m_bvalid) ifc.m_bvalid = 1'b0;
    else if (ifc.m_bready && b_q.size() > 0) begin
      ifc.m_bvalid = 1'b1;
      ifc.m_bresp  = b_q[0].resp;
    end
    if (rand_rdy) begin
      ifc.m_awready = 1'($urandom_range(0, 1));
      ifc.m_wready  = 1'($urandom_range(0, 1));
    end
    if (pop2_pending) begin
      n2--;
      pop2_pending = 0;
    end
    ifc2.fifo_empty = (n2 == 0);
    if (ifc2.m_bvalid) ifc2.m_bvalid = 1'b0;
    else if (ifc2.m_bready) ifc2.m_bvalid = 1'b1;
  end

  // Protocol monitor, sampled mid-cycle.
  logic        stall_aw = 0, stall_w = 0;
  logic [31:0] hold_awaddr = 0, hold_wdata = 0;
  always @(negedge clk) begin : mon
    ent_t e;
    cyc++;
    if (!rst_n) begin
      stall_aw = 0;
      stall_w  = 0;
    end else begin
      if (stall_aw) chk("aw_hold", {ifc.m_awvalid, ifc.m_awaddr}, {1'b1, hold_awaddr});
      if (stall_w)  chk("w_hold", {ifc.m_wvalid, ifc.m_wdata}, {1'b1, hold_wdata});
      if (ifc.fifo_rd_en) begin
        chk("pop_legal", {ifc.fifo_empty, busy}, 2'b00);
        pop_cnt++;
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        pop_pending = 1;
      end
      if (ifc.m_awvalid && ifc.m_awready) begin
        chk("aw_no_overlap", aw_cnt - b_cnt, 0);
        chk("aw_q_depth", aw_q.size(), 1);
        if (aw_q.size() > 0) begin
          e = aw_q.pop_front();
          chk("awaddr", ifc.m_awaddr, e.addr);
        end
        chk("awprot", ifc.m_awprot, 3'b000);
        aw_cnt++;
      end
      if (ifc.m_wvalid && ifc.m_wready) begin
        chk("w_q_depth", w_q.size(), 1);
        if (w_q.size() > 0) begin
          e = w_q.pop_front();
          chk("wdata", ifc.m_wdata, e.data);
        end
        chk("wstrb", ifc.m_wstrb, 4'hF);
        w_cnt++;
      end
      if (ifc.m_bvalid && ifc.m_bready) begin
        b_cnt++;
        if (b_q.size() > 0) void'(b_q.pop_front());
      end
      stall_aw    = ifc.m_awvalid && !ifc.m_awready;
      hold_awaddr = ifc.m_awaddr;
      stall_w     = ifc.m_wvalid && !ifc.m_wready;
      hold_wdata  = ifc.m_wdata;
      if (ifc2.fifo_rd_en) begin
        pop2_pending = 1;
        pop2_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_pops;
    ifc.m_awready = 1'b1; ifc.m_wready = 1'b1;
    ifc.m_bvalid = 1'b0;  ifc.m_bresp = 2'b00;
    fifo_drive();
    ifc2.fifo_empty = 1'b1; ifc2.fifo_addr = 32'h0000_0100; ifc2.fifo_data = 32'hDEAD_BEEF;
    ifc2.m_awready = 1'b1; ifc2.m_wready = 1'b1;
    ifc2.m_bvalid = 1'b0;  ifc2.m_bresp = 2'b10;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {ifc.fifo_rd_en, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready, busy,
                      wr_count, err_count, last_bresp}, '0);
    chk("reset_addr_data", {ifc.m_awaddr, ifc.m_wdata}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Empty FIFO: nothing moves
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {ifc.fifo_rd_en, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready, busy}, '0);
    end
    chk("idle_pops", pop_cnt, 0);

    // Stray B response outside RESP is ignored
    @(negedge clk); #2;
    ifc.m_bvalid = 1'b1; ifc.m_bresp = 2'b11;
    repeat (2) @(negedge clk);
    chk("stray_b_ignored", {wr_count, err_count, last_bresp}, '0);

    // Single write
    @(posedge clk); #1;
    push(32'h0000_0010, 32'hA5A5_A5A5, 2'b00);
    wait_done(50);
    chk("single_counts", {pop_cnt[7:0], aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 32'h01010101);
    check_counts("single");

    // AW held off for 4 cycles, W goes first
    @(posedge clk); #1;
    ifc.m_awready = 1'b0;
    push(32'h0000_0030, 32'h1234_5678, 2'b00);
    repeat (3) @(negedge clk);
    chk("skew_w_first", {ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready}, 3'b100);
    chk("skew_awaddr", ifc.m_awaddr, 32'h0000_0030);
    chk("skew_w_cnt", w_cnt, 2);
    repeat (2) @(negedge clk);
    chk("skew_no_bready", {ifc.m_awvalid, ifc.m_bready, busy}, 3'b101);
    @(posedge clk); #1 ifc.m_awready = 1'b1;
    wait_done(50);
    chk("skew_aw_cnt", aw_cnt, 2);
    check_counts("skew");

    // Two queued entries, second returns SLVERR
    @(posedge clk); #1;
    push(32'h0000_0020, 32'hA5A5_A5A5, 2'b00);
    push(32'h0000_0024, 32'hA5A5_A1A5, 2'b10);
    wait_done(100);
    chk("b2b_pop_gap", last_pop_cyc - prev_pop_cyc, 3);
    chk("b2b_b_cnt", b_cnt, 4);
    check_counts("b2b");

    // Reset pulsed during SEND
    @(posedge clk); #1;
    ifc.m_awready = 1'b0;
    push(32'h0000_0040, 32'h0BAD_F00D, 2'b00);
    repeat (2) @(negedge clk);
    chk("pre_reset_awvalid", ifc.m_awvalid, 1'b1);
    saved_pops = pop_cnt;
    #2 rst_n = 1'b0;
    #1 chk("async_drop", {ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready, busy}, 4'b0000);
    aw_q.delete(); w_q.delete(); b_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    exp_wr = 0; exp_err = 0; exp_last = 2'b00;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifc.m_awready = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_no_reread", pop_cnt, saved_pops);
    check_counts("post_reset");
    @(posedge clk); #1;
    push(32'h0000_0044, 32'hCAFE_0044, 2'b00);
    wait_done(50);
    chk("post_reset_pops", pop_cnt, saved_pops + 1);
    check_counts("post_reset_wr");

    // Randomised traffic with random readies
    rand_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      push($urandom & 32'hFFFF_FFFC, $urandom, 2'($urandom_range(0, 3)));
    end
    wait_done(3000);
    rand_rdy = 0;
    @(posedge clk); #1;
    ifc.m_awready = 1'b1; ifc.m_wready = 1'b1;
    chk("rand_aw_cnt", aw_cnt, 17);
    chk("rand_w_cnt", w_cnt, 17);
    check_counts("rand");

    // Saturation on the 2-bit counter instance: five SLVERR writes
    @(posedge clk); #1 n2 = 5;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(n2 == 0 && !pop2_pending && !busy2) && k < 200);
    end
    repeat (4) @(negedge clk);
    chk("sat_pops", pop2_cnt, 5);
    chk("sat_wr_count", wr_count2, 2'b11);
    chk("sat_err_count", err_count2, 2'b11);
    chk("sat_last_bresp", last_bresp2, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
